// File: rtl/rst_seq_pkg.sv
// -----------------------------------------------------------------------------
// rst_seq_pkg
// Shared types and helpers for the reset sequencer (rst_seq_gen).
//   rst_state_e : sequencer state encoding (2 bits)
//   cnt_width() : width of the shared pulse/gap counter
// -----------------------------------------------------------------------------
package rst_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ASSERT  = 2'd1,
        ST_RELEASE = 2'd2,
        ST_FINISH  = 2'd3
    } rst_state_e;

    // Counter must hold the larger of the two terminal counts.
    function automatic int cnt_width(input int pulse, input int gap);
        int m;
        m = (pulse > gap) ? pulse : gap;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/rst_seq_cnt.sv
// -----------------------------------------------------------------------------
// rst_seq_cnt
// Clearable free-running up-counter with a terminal-count compare. The caller
// selects the terminal value each cycle, so a single instance serves both the
// reset pulse width and the inter-domain release gap.
// Ports:
//   clk_i    : clock
//   arst_ni  : asynchronous active-low reset (counter -> 0)
//   clr_i    : synchronous clear (takes priority over counting)
//   term_i   : terminal value to compare against
//   cnt_o    : current count
//   tc_o     : high while cnt_o == term_i
// -----------------------------------------------------------------------------
module rst_seq_cnt #(
    parameter int W = 5
) (
    input  logic         clk_i,
    input  logic         arst_ni,
    input  logic         clr_i,
    input  logic [W-1:0] term_i,
    output logic [W-1:0] cnt_o,
    output logic         tc_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: clear or increment.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
    assign tc_o  = (cnt_q == term_i);

endmodule

// File: rtl/rst_seq_gen.sv
// -----------------------------------------------------------------------------
// rst_seq_gen
// Reset sequencer. Holds all NUM_DOMAINS active-low resets asserted for
// PULSE_CYCLES clocks, then releases them one at a time (bit 0 first) every
// GAP_CYCLES clocks, and pulses done for one cycle after the last release.
// A sequence is started by arst_n (asynchronously forced) or by sw_rst_req
// while idle.
// Ports:
//   clk        : system clock
//   arst_n     : async active-low reset, synchronously deasserted upstream
//   sw_rst_req : single-cycle software reset request
//   rst_n_out  : registered active-low domain resets
//   busy       : registered, sequence in progress
//   done       : registered, one-cycle pulse after the last release
// Optional build macro:
//   RST_SEQ_PENDING_EN : requests seen while busy are remembered (collapsed to
//                        one) and start a new sequence straight from FINISH.
//                        Without it such requests are dropped.
// -----------------------------------------------------------------------------
module rst_seq_gen
    import rst_seq_pkg::*;
#(
    parameter int NUM_DOMAINS  = 4,
    parameter int PULSE_CYCLES = 16,
    parameter int GAP_CYCLES   = 4
) (
    input  logic                   clk,
    input  logic                   arst_n,
    input  logic                   sw_rst_req,
    output logic [NUM_DOMAINS-1:0] rst_n_out,
    output logic                   busy,
    output logic                   done
);

    localparam int CNT_W = cnt_width(PULSE_CYCLES, GAP_CYCLES);
    localparam int IDX_W = $clog2(NUM_DOMAINS) + 1;

    rst_state_e             state_q;
    logic [IDX_W-1:0]       idx_q;
    logic [NUM_DOMAINS-1:0] rst_n_out_q;
    logic                   busy_q;
    logic                   done_q;

    logic                   cnt_clr_s;
    logic [CNT_W-1:0]       cnt_term_s;
    logic [CNT_W-1:0]       cnt_s;
    logic                   cnt_tc_s;
    logic [NUM_DOMAINS-1:0] rel_mask_s;
    logic                   last_idx_s;
    logic                   restart_s;

    rst_seq_cnt #(
        .W (CNT_W)
    ) u_cnt (
        .clk_i   (clk),
        .arst_ni (arst_n),
        .clr_i   (cnt_clr_s),
        .term_i  (cnt_term_s),
        .cnt_o   (cnt_s),
        .tc_o    (cnt_tc_s)
    );

    // Terminal select: in RELEASE the first domain goes one cycle after
    // entry (terminal 0); later domains wait a full gap. The counter is
    // cleared on every hit and held at zero outside ASSERT/RELEASE.
    always_comb begin
        cnt_term_s = '0;
        cnt_clr_s  = 1'b1;
        case (state_q)
            ST_ASSERT: begin
                cnt_term_s = CNT_W'(PULSE_CYCLES - 1);
                cnt_clr_s  = cnt_tc_s;
            end
            ST_RELEASE: begin
                if (idx_q == '0) begin
                    cnt_term_s = '0;
                end else begin
                    cnt_term_s = CNT_W'(GAP_CYCLES - 1);
                end
                cnt_clr_s = cnt_tc_s;
            end
            default: begin
                cnt_term_s = '0;
                cnt_clr_s  = 1'b1;
            end
        endcase
    end

    // One-hot mask of the domain currently being released.
    always_comb begin
        rel_mask_s = '0;
        for (int i = 0; i < NUM_DOMAINS; i++) begin
            rel_mask_s[i] = (idx_q == IDX_W'(i));
        end
        last_idx_s = (idx_q == IDX_W'(NUM_DOMAINS - 1));
    end

`ifdef RST_SEQ_PENDING_EN
    logic pending_q;

    // Remember one request arriving while a sequence is running.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            pending_q <= 1'b0;
        end else if (state_q == ST_FINISH) begin
            pending_q <= 1'b0;
        end else if ((state_q != ST_IDLE) && sw_rst_req) begin
            pending_q <= 1'b1;
        end else begin
            pending_q <= pending_q;
        end
    end

    // A request in the FINISH cycle itself also counts as pending.
    assign restart_s = pending_q | sw_rst_req;
`else
    assign restart_s = 1'b0;
`endif

    // Sequencer FSM with registered outputs.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q     <= ST_ASSERT;
            idx_q       <= '0;
            rst_n_out_q <= '0;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    rst_n_out_q <= {NUM_DOMAINS{1'b1}};
                    busy_q      <= 1'b0;
                    done_q      <= 1'b0;
                    idx_q       <= '0;
                    if (sw_rst_req) begin
                        state_q <= ST_ASSERT;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_ASSERT: begin
                    rst_n_out_q <= '0;
                    busy_q      <= 1'b1;
                    done_q      <= 1'b0;
                    idx_q       <= '0;
                    if (cnt_tc_s) begin
                        state_q <= ST_RELEASE;
                    end else begin
                        state_q <= ST_ASSERT;
                    end
                end
                ST_RELEASE: begin
                    busy_q <= 1'b1;
                    done_q <= 1'b0;
                    if (cnt_tc_s) begin
                        rst_n_out_q <= rst_n_out_q | rel_mask_s;
                        if (last_idx_s) begin
                            state_q <= ST_FINISH;
                        end else begin
                            idx_q   <= idx_q + IDX_W'(1);
                            state_q <= ST_RELEASE;
                        end
                    end else begin
                        state_q <= ST_RELEASE;
                    end
                end
                ST_FINISH: begin
                    rst_n_out_q <= {NUM_DOMAINS{1'b1}};
                    busy_q      <= 1'b0;
                    done_q      <= 1'b1;
                    idx_q       <= '0;
                    if (restart_s) begin
                        state_q <= ST_ASSERT;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q     <= ST_ASSERT;
                    idx_q       <= '0;
                    rst_n_out_q <= '0;
                    busy_q      <= 1'b1;
                    done_q      <= 1'b0;
                end
            endcase
        end
    end

    assign rst_n_out = rst_n_out_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_rst_seq_gen.sv
// -----------------------------------------------------------------------------
// tb_rst_seq_gen
// Self-checking bench for rst_seq_gen (default parameters). A timing model
// derives every output from "edges since the sequence start" and is compared
// on every clock; directed literal checks pin the model's key timings.
// Honors RST_SEQ_PENDING_EN in the model when the build defines it.
// -----------------------------------------------------------------------------
module tb_rst_seq_gen;

    localparam int N  = 4;
    localparam int P  = 16;
    localparam int G  = 4;
    localparam int FK = P + 2 + (N - 1) * G;   // edge offset of the done pulse

`ifdef RST_SEQ_PENDING_EN
    localparam bit PEND_EN = 1'b1;
`else
    localparam bit PEND_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         arst_n = 1'b0;
    logic         sw_rst_req = 1'b0;
    logic [N-1:0] rst_n_out;
    logic         busy;
    logic         done;

    int checks   = 0;
    int failures = 0;

    rst_seq_gen #(
        .NUM_DOMAINS  (N),
        .PULSE_CYCLES (P),
        .GAP_CYCLES   (G)
    ) dut (
        .clk        (clk),
        .arst_n     (arst_n),
        .sw_rst_req (sw_rst_req),
        .rst_n_out  (rst_n_out),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    // Expected outputs k edges after the edge that started the sequence.
    function automatic void model_at(input int k, output logic [N-1:0] r,
                                     output logic b, output logic d);
        r = '1;
        b = 1'b0;
        d = 1'b0;
        if (k >= 1 && k < FK) begin
            b = 1'b1;
            for (int i = 0; i < N; i++) r[i] = (k >= P + 1 + i * G);
        end else if (k == FK) begin
            d = 1'b1;
        end
    endfunction

    int           e_q = 0;      // active edges counted since time zero
    int           t_q = 0;      // edge at which the current sequence started
    bit           pend_q = 1'b0;
    logic [N-1:0] exp_rst;
    logic         exp_busy;
    logic         exp_done;

    // Model update and per-cycle compare.
    always @(posedge clk) begin
        if (!arst_n) begin
            exp_rst  = '0;
            exp_busy = 1'b1;
            exp_done = 1'b0;
            t_q      = e_q;     // next active edge is t+1
            pend_q   = 1'b0;
        end else begin
            e_q++;
            model_at(e_q - t_q, exp_rst, exp_busy, exp_done);
            if (sw_rst_req) begin
                if (e_q > t_q + FK) t_q = e_q;
                else if (PEND_EN) pend_q = 1'b1;
            end
            if (PEND_EN && pend_q && (e_q == t_q + FK)) begin
                t_q    = e_q;
                pend_q = 1'b0;
            end
        end
        #1;
        checks++;
        if (rst_n_out !== exp_rst || busy !== exp_busy || done !== exp_done) begin
            failures++;
            $display("FAIL cycle_model edge=%0d got rst_n_out=%b busy=%b done=%b want rst_n_out=%b busy=%b done=%b",
                     e_q, rst_n_out, busy, done, exp_rst, exp_busy, exp_done);
        end
    end

    task automatic pin(input string name, input logic [N-1:0] r, input logic b, input logic d);
        checks++;
        if (rst_n_out !== r || busy !== b || done !== d) begin
            failures++;
            $display("FAIL %s got rst_n_out=%b busy=%b done=%b want rst_n_out=%b busy=%b done=%b",
                     name, rst_n_out, busy, done, r, b, d);
        end
    endtask

    task automatic pulse_req();
        @(negedge clk);
        sw_rst_req = 1'b1;
        @(negedge clk);
        sw_rst_req = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(posedge clk);
            #2;
            if (done === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL %s_timeout got done=0 for 100 cycles want done=1", name);
        end
    endtask

    initial begin
        // Power-on reset.
        repeat (5) @(negedge clk);
        pin("por_hold", 4'b0000, 1'b1, 1'b0);
        arst_n = 1'b1;
        for (int e = 0; e <= 30; e++) begin
            @(posedge clk);
            #2;
            if (e == 15) pin("por_e15", 4'b0000, 1'b1, 1'b0);
            if (e == 16) pin("por_e16", 4'b0001, 1'b1, 1'b0);
            if (e == 20) pin("por_e20", 4'b0011, 1'b1, 1'b0);
            if (e == 24) pin("por_e24", 4'b0111, 1'b1, 1'b0);
            if (e == 28) pin("por_e28", 4'b1111, 1'b1, 1'b0);
            if (e == 29) pin("por_e29", 4'b1111, 1'b0, 1'b1);
            if (e == 30) pin("por_e30", 4'b1111, 1'b0, 1'b0);
        end
        repeat (5) @(negedge clk);

        // Soft reset, then a request on the IDLE cycle right after done.
        pulse_req();
        for (int j = 1; j <= 30; j++) begin
            @(posedge clk);
            #2;
            if (j == 1)  pin("sw_t1",  4'b0000, 1'b1, 1'b0);
            if (j == 16) pin("sw_t16", 4'b0000, 1'b1, 1'b0);
            if (j == 17) pin("sw_t17", 4'b0001, 1'b1, 1'b0);
            if (j == 21) pin("sw_t21", 4'b0011, 1'b1, 1'b0);
            if (j == 29) pin("sw_t29", 4'b1111, 1'b1, 1'b0);
            if (j == 30) pin("sw_t30", 4'b1111, 1'b0, 1'b1);
        end
        pulse_req();
        @(posedge clk);
        #2;
        pin("b2b_start", 4'b0000, 1'b1, 1'b0);
        wait_done("b2b");
        repeat (5) @(negedge clk);

        // Request while busy (dropped, or pending when the feature is built).
        pulse_req();
        repeat (9) @(negedge clk);
        pulse_req();
        wait_done("busy_req");
        repeat (45) @(negedge clk);

        // Asynchronous reset in mid-sequence, then full power-on timing.
        pulse_req();
        repeat (22) @(negedge clk);
        #1 arst_n = 1'b0;
        #1 pin("async_now", 4'b0000, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        arst_n = 1'b1;
        for (int e = 0; e <= 29; e++) begin
            @(posedge clk);
            #2;
            if (e == 15) pin("rerst_e15", 4'b0000, 1'b1, 1'b0);
            if (e == 16) pin("rerst_e16", 4'b0001, 1'b1, 1'b0);
            if (e == 29) pin("rerst_e29", 4'b1111, 1'b0, 1'b1);
        end

        // Random requests with occasional asynchronous resets.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 399) == 0) begin
                sw_rst_req = 1'b0;
                #1 arst_n = 1'b0;
                #1 pin("rand_async", 4'b0000, 1'b1, 1'b0);
                repeat ($urandom_range(1, 4)) @(negedge clk);
                arst_n = 1'b1;
            end else begin
                sw_rst_req = ($urandom_range(0, 15) == 0);
            end
        end
        @(negedge clk);
        sw_rst_req = 1'b0;
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
